caxi4interconnect_upsize_lane_sequencer: RTL and testbench
==========================================================

// Module: caxi4interconnect_upsize_lane_sequencer
// PURPOSE
//  Sequences the lane-sliced upsizing FIFO (N narrow RAM lanes, wide read port, one shared wr/rd pointer pair).
//  Steers each accepted narrow beat into its lane and zero-fills unused lanes at burst start and partial end.
//  Pushes a wide word when the top lane is written, and drains the FIFO into a one-entry wide output register
//  through a valid/ready handshake. Sits between the narrow-side write channel and the wide-side slave port.
// PARAMETERS
//  DATA_WIDTH_IN   32   narrow beat width (bits)
//  DATA_WIDTH_OUT  128  wide word width; multiple of DATA_WIDTH_IN, RATIO = DATA_WIDTH_OUT/DATA_WIDTH_IN >= 2
//  LANE_W          derived localparam = $clog2(RATIO), min 1
// PORTS
//  clk              in   1       clock
//  rst              in   1       asynchronous active-low reset
//  s_valid          in   1       narrow beat valid
//  s_ready          out  1       narrow beat ready
//  s_first          in   1       beat is first of burst; s_start_lane is sampled with it
//  s_start_lane     in   LANE_W  lane of first beat (address offset / DATA_WIDTH_IN)
//  s_last           in   1       beat is last of burst
//  fifo_wr_en       out  RATIO   one-hot lane write enable
//  fifo_zero_data   out  RATIO   lanes written with zero this cycle
//  fifo_full        in   1       FIFO full flag
//  fifo_empty       in   1       FIFO empty flag
//  fifo_rd_en       out  1       advance FIFO read pointer
//  fifo_pass_data   out  1       load FIFO output register from RAM read data
//  fifo_zero_out_data out 1      tied 0
//  m_valid          out  1       wide word in FIFO output register is valid
//  m_ready          in   1       wide side accepts word
// BEHAVIOUR
//  - Reset (rst=0, async): lane_ptr=0, read FSM=EMPTY; all outputs 0 except s_ready = !fifo_full.
//  - s_ready = !fifo_full (combinational); beat accepted when s_valid & s_ready.
//  - Beat lane L = s_first ? s_start_lane : lane_ptr. Accepted beat: fifo_wr_en[L]=1, same cycle.
//  - Zero fill, same cycle as the beat: s_first & L>0 -> fifo_zero_data[L-1:0]=1;
//    s_last & L<RATIO-1 -> fifo_zero_data[RATIO-1:L+1]=1. Never zero a lane carrying data.
//  - Push (FIFO pointer advance) occurs when lane RATIO-1 is written or zeroed; at most one push per cycle.
//  - lane_ptr next: s_last or L=RATIO-1 -> 0; else L+1. Wraps mod RATIO. No beat -> hold.
//  - No beat accepted: fifo_wr_en=0, fifo_zero_data=0 (except flush, see CONFIGURATION).
//  - RAM read data is combinational from rd_addr; output register updates on fifo_pass_data.
//  - Read FSM: EMPTY: !fifo_empty -> pass_data=1, rd_en=1 -> FULL. Else stay, m_valid=0.
//    FULL (m_valid=1): m_ready & !fifo_empty -> pass_data=1, rd_en=1, stay (back-to-back, 1 word/clk);
//    m_ready & fifo_empty -> EMPTY; !m_ready -> hold, pass_data=0, rd_en=0, output stable.
//  - Simultaneous push and rd_en legal; fifo_empty as seen by FSM is the FIFO's registered flag.
//  - Reset mid-burst discards partial word and output register; no zero fill on reset.
//  - s_first with lane_ptr!=0 (previous burst lacked s_last): s_start_lane wins, stale lanes overwritten, no push.
// CONFIGURATION
//  - Macro CAXI4_UPSIZE_SEQ_FLUSH_EN defined: adds ports flush_req (in,1), flush_ack (out,1).
//    flush_req & lane_ptr!=0 & no beat accepted & !fifo_full -> fifo_zero_data[RATIO-1:lane_ptr]=1 (push),
//    lane_ptr<=0, flush_ack=1 for that cycle. flush_req with lane_ptr=0 -> flush_ack=1, no write.
//    Beat accepted in the same cycle takes priority; flush retried next cycle.
//  - Not defined: ports absent; partial words pushed only on s_last.
// TESTING (RATIO=4, 32->128)
//  1. s_first, start_lane=0, 4 beats A,B,C,D(last) -> wr_en 0001,0010,0100,1000; one push; m_data={D,C,B,A}.
//  2. s_first, start_lane=2, beats A,B(last) -> cyc1 wr_en=0100 zero=0011; cyc2 wr_en=1000; m_data={B,A,0,0}.
//  3. single beat s_first&s_last, start_lane=1, data A -> wr_en=0010, zero=1101 same cycle; m_data={0,0,A,0}.
//  4. fifo_full=1 with s_valid=1 -> s_ready=0, wr_en=0, zero=0, lane_ptr unchanged.
//  5. 3 words queued, m_ready=0 for 5 clks -> m_valid=1, data stable, rd_en=0; m_ready=1 -> 3 words on 3
//     consecutive clks, then m_valid=0.
//  6. FLUSH_EN: 2 beats at lanes 0,1 no last, flush_req -> zero=1100, flush_ack=1, m_data={0,0,B,A}.

Source files
------------

// File: rtl/caxi4interconnect_upsize_lane_sequencer.sv
// Lane steering, zero fill and read-side handshake for the lane-sliced upsizing FIFO.
// Optional partial-word flush port pair enabled by defining CAXI4_UPSIZE_SEQ_FLUSH_EN.
module caxi4interconnect_upsize_lane_sequencer #(
    parameter int DATA_WIDTH_IN   = 32,
    parameter int DATA_WIDTH_OUT  = 128,
    localparam int RATIO  = DATA_WIDTH_OUT / DATA_WIDTH_IN,
    localparam int LANE_W = (RATIO > 2) ? $clog2(RATIO) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_first,
    input  logic [LANE_W-1:0] s_start_lane,
    input  logic              s_last,
    output logic [RATIO-1:0]  fifo_wr_en,
    output logic [RATIO-1:0]  fifo_zero_data,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              fifo_pass_data,
    output logic              fifo_zero_out_data,
`ifdef CAXI4_UPSIZE_SEQ_FLUSH_EN
    input  logic              flush_req,
    output logic              flush_ack,
`endif
    output logic              m_valid,
    input  logic              m_ready
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [LANE_W-1:0] lane_ptr;
    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] lane_nxt;
    logic              beat;
    logic [0:0]        rd_state;
    logic [0:0]        rd_state_nxt;

    // Reset gates every write strobe so a beat presented during reset never lands.
    assign s_ready            = !fifo_full;
    assign beat               = s_valid && !fifo_full && rst;
    assign lane               = s_first ? s_start_lane : lane_ptr;
    assign fifo_zero_out_data = 1'b0;
    assign m_valid            = (rd_state == ST_FULL);

    always_comb begin
        fifo_wr_en     = '0;
        fifo_zero_data = '0;
        lane_nxt       = lane_ptr;
`ifdef CAXI4_UPSIZE_SEQ_FLUSH_EN
        flush_ack      = 1'b0;
`endif
        if (beat) begin
            for (int i = 0; i < RATIO; i++) begin
                if (i == int'(lane))
                    fifo_wr_en[i] = 1'b1;
                if (s_first && (i < int'(lane)))
                    fifo_zero_data[i] = 1'b1;
                if (s_last && (i > int'(lane)))
                    fifo_zero_data[i] = 1'b1;
            end
            if (s_last || (int'(lane) == RATIO - 1))
                lane_nxt = '0;
            else
                lane_nxt = lane + LANE_W'(1);
        end
`ifdef CAXI4_UPSIZE_SEQ_FLUSH_EN
        // A flush only fills the untouched upper lanes, so the top lane zero causes the push.
        else if (flush_req && rst) begin
            if (lane_ptr == '0) begin
                flush_ack = 1'b1;
            end else if (!fifo_full) begin
                for (int i = 0; i < RATIO; i++) begin
                    if (i >= int'(lane_ptr))
                        fifo_zero_data[i] = 1'b1;
                end
                lane_nxt  = '0;
                flush_ack = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lane_ptr <= '0;
        else
            lane_ptr <= lane_nxt;
    end

    // Output register keeps the word until m_ready; a fresh word follows the same clock.
    always_comb begin
        fifo_rd_en     = 1'b0;
        fifo_pass_data = 1'b0;
        rd_state_nxt   = rd_state;
        if (rst) begin
            case (rd_state)
                ST_EMPTY: begin
                    if (!fifo_empty) begin
                        fifo_rd_en     = 1'b1;
                        fifo_pass_data = 1'b1;
                        rd_state_nxt   = ST_FULL;
                    end
                end
                default: begin
                    if (m_ready) begin
                        if (!fifo_empty) begin
                            fifo_rd_en     = 1'b1;
                            fifo_pass_data = 1'b1;
                        end else begin
                            rd_state_nxt = ST_EMPTY;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_state <= ST_EMPTY;
        else
            rd_state <= rd_state_nxt;
    end

endmodule

// File: tb/tb_caxi4interconnect_upsize_lane_sequencer.sv
// Directed bench for caxi4interconnect_upsize_lane_sequencer with a lane-sliced FIFO model around it.
module tb_caxi4interconnect_upsize_lane_sequencer;

    localparam int RATIO = 4;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s_valid, s_ready, s_first, s_last;
    logic [1:0]   s_start_lane;
    logic [31:0]  s_data;
    logic [3:0]   fifo_wr_en, fifo_zero_data;
    logic         fifo_full, fifo_empty, fifo_rd_en, fifo_pass_data, fifo_zero_out_data;
    logic         m_valid, m_ready;
    logic         force_full;
    logic         flush_req;
    logic         flush_ack;

    always #5 clk = ~clk;

    caxi4interconnect_upsize_lane_sequencer #(
        .DATA_WIDTH_IN (32),
        .DATA_WIDTH_OUT(128)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_first           (s_first),
        .s_start_lane      (s_start_lane),
        .s_last            (s_last),
        .fifo_wr_en        (fifo_wr_en),
        .fifo_zero_data    (fifo_zero_data),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_rd_en        (fifo_rd_en),
        .fifo_pass_data    (fifo_pass_data),
        .fifo_zero_out_data(fifo_zero_out_data),
`ifdef CAXI4_UPSIZE_SEQ_FLUSH_EN
        .flush_req         (flush_req),
        .flush_ack         (flush_ack),
`endif
        .m_valid           (m_valid),
        .m_ready           (m_ready)
    );

`ifndef CAXI4_UPSIZE_SEQ_FLUSH_EN
    assign flush_ack = 1'b0;
`endif

    // Lane-sliced FIFO: RAM filled with a marker so missing zero fill shows up in the data.
    logic [31:0]  ram [DEPTH][RATIO];
    int           wr_ptr, rd_ptr, count;
    logic [127:0] m_data;
    logic         push;

    assign push       = fifo_wr_en[RATIO-1] | fifo_zero_data[RATIO-1];
    assign fifo_full  = force_full || (count == DEPTH);
    assign fifo_empty = (count == 0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 0;
            rd_ptr <= 0;
            count  <= 0;
            m_data <= '0;
            for (int e = 0; e < DEPTH; e++)
                for (int l = 0; l < RATIO; l++)
                    ram[e][l] <= 32'hDEADBEEF;
        end else begin
            for (int l = 0; l < RATIO; l++) begin
                if (fifo_wr_en[l])
                    ram[wr_ptr][l] <= s_data;
                else if (fifo_zero_data[l])
                    ram[wr_ptr][l] <= 32'h0;
            end
            if (push)
                wr_ptr <= (wr_ptr + 1) % DEPTH;
            if (fifo_rd_en)
                rd_ptr <= (rd_ptr + 1) % DEPTH;
            count <= count + (push ? 1 : 0) - (fifo_rd_en ? 1 : 0);
            if (fifo_pass_data)
                m_data <= {ram[rd_ptr][3], ram[rd_ptr][2], ram[rd_ptr][1], ram[rd_ptr][0]};
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic        f;
        logic [1:0]  sl;
        logic        l;
        logic        full;
        logic [31:0] d;
        logic [3:0]  wr;
        logic [3:0]  zr;
        logic        rdy;
    } vec_t;

    vec_t         vec [13];
    logic [127:0] words [5];

    initial begin
        //            v     f     sl     l     full  data           wr       zero     rdy
        vec[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'h11111111, 4'b0001, 4'b0000, 1'b1};
        vec[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h22222222, 4'b0010, 4'b0000, 1'b1};
        vec[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h33333333, 4'b0100, 4'b0000, 1'b1};
        vec[3]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'h44444444, 4'b1000, 4'b0000, 1'b1};
        vec[4]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,        4'b0000, 4'b0000, 1'b1};
        vec[5]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h55555555, 4'b0100, 4'b0011, 1'b1};
        vec[6]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'h66666666, 4'b1000, 4'b0000, 1'b1};
        vec[7]  = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 32'h77777777, 4'b0010, 4'b1101, 1'b1};
        vec[8]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 32'h88888888, 4'b0010, 4'b0001, 1'b1};
        vec[9]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 32'hEEEEEEEE, 4'b0000, 4'b0000, 1'b0};
        vec[10] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'h99999999, 4'b0100, 4'b1000, 1'b1};
        vec[11] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'hAAAAAAAA, 4'b0001, 4'b0000, 1'b1};
        vec[12] = '{1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 32'hBBBBBBBB, 4'b1000, 4'b0111, 1'b1};
        words[0] = 128'h44444444_33333333_22222222_11111111;
        words[1] = 128'h66666666_55555555_00000000_00000000;
        words[2] = 128'h00000000_00000000_77777777_00000000;
        words[3] = 128'h00000000_99999999_88888888_00000000;
        words[4] = 128'hBBBBBBBB_00000000_00000000_00000000;

        // Reset held with a beat presented: nothing may be written or read.
        s_valid = 1'b1; s_first = 1'b1; s_last = 1'b1; s_start_lane = 2'd1;
        s_data = 32'hCAFEF00D; force_full = 1'b0; m_ready = 1'b0; flush_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset wr_en", fifo_wr_en, 4'b0000);
        check("reset zero", fifo_zero_data, 4'b0000);
        check("reset s_ready", s_ready, 1'b1);
        check("reset m_valid", m_valid, 1'b0);
        check("reset rd_en", fifo_rd_en, 1'b0);
        check("reset pass", fifo_pass_data, 1'b0);
        check("reset zero_out", fifo_zero_out_data, 1'b0);
        check("reset flush_ack", flush_ack, 1'b0);
        s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; s_start_lane = 2'd0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            s_valid = vec[i].v; s_first = vec[i].f; s_start_lane = vec[i].sl;
            s_last = vec[i].l; force_full = vec[i].full; s_data = vec[i].d;
            #1;
            check($sformatf("vec%0d wr_en", i), fifo_wr_en, vec[i].wr);
            check($sformatf("vec%0d zero", i), fifo_zero_data, vec[i].zr);
            check($sformatf("vec%0d s_ready", i), s_ready, vec[i].rdy);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; force_full = 1'b0;

        // Wide side stalled: first word held stable, no reads.
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("hold%0d m_valid", k), m_valid, 1'b1);
            check($sformatf("hold%0d rd_en", k), fifo_rd_en, 1'b0);
            check($sformatf("hold%0d m_data", k), m_data, words[0]);
            @(posedge clk);
            #1;
        end

        // Released: one word per clock, then empty.
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("drain%0d m_valid", k), m_valid, 1'b1);
            check($sformatf("drain%0d m_data", k), m_data, words[k]);
            check($sformatf("drain%0d rd_en", k), fifo_rd_en, (k < 4) ? 1'b1 : 1'b0);
            @(posedge clk);
            #1;
        end
        check("drained m_valid", m_valid, 1'b0);
        m_ready = 1'b0;

`ifdef CAXI4_UPSIZE_SEQ_FLUSH_EN
        s_valid = 1'b1; s_first = 1'b1; s_start_lane = 2'd0; s_data = 32'hC1C1C1C1;
        @(posedge clk);
        #1;
        s_first = 1'b0; s_data = 32'hC2C2C2C2;
        @(posedge clk);
        #1;
        s_valid = 1'b0; flush_req = 1'b1;
        #1;
        check("flush zero", fifo_zero_data, 4'b1100);
        check("flush wr_en", fifo_wr_en, 4'b0000);
        check("flush ack", flush_ack, 1'b1);
        @(posedge clk);
        #1;
        check("flush idle ack", flush_ack, 1'b1);
        check("flush idle zero", fifo_zero_data, 4'b0000);
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        check("flush m_valid", m_valid, 1'b1);
        check("flush m_data", m_data, 128'h00000000_00000000_C2C2C2C2_C1C1C1C1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
